// File: rtl/bus_demux.sv
// -----------------------------------------------------------------------------
// bus_demux
//
// Write-side counterpart of the CPU's 8-way bus multiplexer. A word from the
// internal data bus and a 3-bit destination index are accepted over a
// valid/ready handshake. On the following edge the word is committed into one
// of eight held destination registers, and a one-cycle one-hot load strobe
// marks which destination changed.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   bus_in    word to write, sampled on handshake
//   sel       destination index 0..7, sampled on handshake
//   wr_valid  source offers bus_in/sel this cycle
//   wr_ready  block can accept a write this cycle (combinational)
//   clr       synchronous clear of all destinations and any pending commit
//   out_0..7  held destination registers
//   ld        one-hot load strobe, bit i pulses for one cycle when out_i loads
//   busy      a captured write is waiting for its commit edge (combinational)
// -----------------------------------------------------------------------------
module bus_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [2:0]       sel,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [WIDTH-1:0] out_4,
  output logic [WIDTH-1:0] out_5,
  output logic [WIDTH-1:0] out_6,
  output logic [WIDTH-1:0] out_7,
  output logic [7:0]       ld,
  output logic             busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [2:0]       hold_sel_q,  hold_sel_d;
  logic [WIDTH-1:0] out_q [8];
  logic [WIDTH-1:0] out_d [8];
  logic [7:0]       ld_q,        ld_d;

  // clr gates wr_ready so a handshake can never coincide with a clear.
  assign wr_ready = (state_q == IDLE) && !clr;
  assign busy     = (state_q == COMMIT);

  // NOTE: every variable gets a default before any branch, so no path leaves
  // a combinational output unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_sel_d  = hold_sel_q;
    out_d       = out_q;
    ld_d        = '0;        // strobe is a single-cycle pulse by default

    if (clr) begin
      // Discards a pending commit; no strobe is produced for it.
      state_d     = IDLE;
      hold_data_d = '0;
      hold_sel_d  = '0;
      out_d       = '{default: '0};
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_valid && wr_ready) begin
            hold_data_d = bus_in;
            hold_sel_d  = sel;
            state_d     = COMMIT;
          end
        end
        COMMIT: begin
          // wr_valid is deliberately ignored here; wr_ready is low.
          out_d[hold_sel_q] = hold_data_q;
          ld_d[hold_sel_q]  = 1'b1;
          state_d           = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the destination array is a small bank of flops, not a RAM, so it is
  // reset along with the rest; a reset must leave every destination at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_sel_q  <= '0;
      out_q       <= '{default: '0};
      ld_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before the edge, independent of statement order.
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
      out_q       <= out_d;
      ld_q        <= ld_d;
    end
  end

  assign out_0 = out_q[0];
  assign out_1 = out_q[1];
  assign out_2 = out_q[2];
  assign out_3 = out_q[3];
  assign out_4 = out_q[4];
  assign out_5 = out_q[5];
  assign out_6 = out_q[6];
  assign out_7 = out_q[7];
  assign ld    = ld_q;

endmodule

// File: tb/tb_bus_demux.sv
// -----------------------------------------------------------------------------
// tb_bus_demux
//
// Self-checking bench for bus_demux. A behavioural model (eight destination
// values plus an optional pending write) is compared against every DUT output
// on each falling clock edge; directed scenarios add literal expectations and
// a randomized phase mixes writes, idle gaps, clears and async resets.
// -----------------------------------------------------------------------------
module tb_bus_demux;

  localparam int WIDTH = 8;
  localparam int TCLK  = 10;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] bus_in;
  logic [2:0]       sel;
  logic             wr_valid;
  logic             wr_ready;
  logic             clr;
  logic [WIDTH-1:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
  logic [7:0]       ld;
  logic             busy;

  bus_demux #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_in   (bus_in),
    .sel      (sel),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .clr      (clr),
    .out_0    (out_0),
    .out_1    (out_1),
    .out_2    (out_2),
    .out_3    (out_3),
    .out_4    (out_4),
    .out_5    (out_5),
    .out_6    (out_6),
    .out_7    (out_7),
    .ld       (ld),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #(TCLK/2) clk = ~clk;

  logic [WIDTH-1:0] dut_out [8];
  always_comb begin
    dut_out[0] = out_0; dut_out[1] = out_1; dut_out[2] = out_2; dut_out[3] = out_3;
    dut_out[4] = out_4; dut_out[5] = out_5; dut_out[6] = out_6; dut_out[7] = out_7;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: destination values, last strobe, and at most one
  // accepted-but-not-yet-committed write.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] m_out [8];
  logic [7:0]       m_ld;
  bit               m_pend;
  logic [2:0]       m_sel;
  logic [WIDTH-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      m_out  <= '{default: '0};
      m_ld   <= '0;
      m_pend <= 1'b0;
    end else if (m_pend) begin
      m_out[m_sel] <= m_data;
      m_ld         <= 8'(1 << m_sel);
      m_pend       <= 1'b0;
    end else begin
      m_ld <= '0;
      if (wr_valid) begin
        m_pend <= 1'b1;
        m_sel  <= sel;
        m_data <= bus_in;
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 8; i++) check($sformatf("out_%0d", i), 32'(dut_out[i]), 32'(m_out[i]));
      check("ld",       32'(ld),       32'(m_ld));
      check("busy",     32'(busy),     32'(m_pend));
      check("wr_ready", 32'(wr_ready), 32'(!m_pend && !clr));
    end
  end

  int ld2_cnt = 0;
  always @(negedge clk) if (ld[2] === 1'b1) ld2_cnt++;

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All drivers are called at posedge+1.
  // ---------------------------------------------------------------------------
  time last_hs;

  // Offer a write and hold it until it is accepted; returns at (handshake
  // edge + 1) with wr_valid still high.
  task automatic do_write(input logic [2:0] s, input logic [WIDTH-1:0] d);
    bit ok = 1'b0;
    sel      = s;
    bus_in   = d;
    wr_valid = 1'b1;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      if (wr_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      last_hs = $time;
      #1;
    end
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    wr_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_first;

    rst_n    = 1'b1;
    clr      = 1'b0;
    wr_valid = 1'b0;
    sel      = '0;
    bus_in   = '0;

    // --- Reset asserted mid-cycle takes effect immediately -------------------
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) check("rst_out", 32'(dut_out[i]), 32'h00);
    check("rst_ld",   32'(ld),   32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    #20 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);

    // --- Single write: sel 5, 0xA7 -------------------------------------------
    do_write(3'd5, 8'hA7);
    wr_valid = 1'b0;
    check("single_busy", 32'(busy), 32'd1);
    @(posedge clk); #2;
    check("single_out5", 32'(out_5), 32'hA7);
    check("single_ld",   32'(ld),    32'h20);
    check("single_out4", 32'(out_4), 32'h00);
    @(posedge clk); #2;
    check("single_ld_drop", 32'(ld), 32'h00);
    #1;

    // --- Back-to-back with wr_valid held ------------------------------------
    do_write(3'd0, 8'h11);
    t_first = last_hs;
    do_write(3'd7, 8'hEE);
    wr_valid = 1'b0;
    check("b2b_spacing", 32'(last_hs - t_first), 32'(2*TCLK));
    check("b2b_out0",    32'(out_0), 32'h11);
    @(posedge clk); #2;
    check("b2b_out7", 32'(out_7), 32'hEE);
    check("b2b_ld",   32'(ld),    32'h80);
    check("b2b_out5", 32'(out_5), 32'hA7);
    #1;

    // --- Overwrite the same destination -------------------------------------
    ld2_cnt = 0;
    do_write(3'd2, 8'h3C);
    do_write(3'd2, 8'hC3);
    idle_cycles(3);
    check("ovw_out2",   32'(out_2), 32'hC3);
    check("ovw_ld2cnt", 32'(ld2_cnt), 32'd2);

    // --- clr during COMMIT ---------------------------------------------------
    do_write(3'd3, 8'h55);
    clr    = 1'b1;
    sel    = 3'd4;
    bus_in = 8'h77;
    #3;
    check("clr_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    clr      = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("clr_out3", 32'(out_3), 32'h00);
    check("clr_out7", 32'(out_7), 32'h00);
    check("clr_ld",   32'(ld),    32'h00);
    check("clr_busy", 32'(busy),  32'd0);
    @(posedge clk); #2;
    check("clr_out4", 32'(out_4), 32'h00);
    check("clr_ld2",  32'(ld),    32'h00);
    #1;

    // --- Reset mid-COMMIT ----------------------------------------------------
    do_write(3'd6, 8'h9A);
    wr_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 check("rstc_busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    check("rstc_out6", 32'(out_6), 32'h00);
    check("rstc_ld",   32'(ld),    32'h00);
    #1;
    do_write(3'd6, 8'h21);
    wr_valid = 1'b0;
    @(posedge clk); #2;
    check("rstc_next_out6", 32'(out_6), 32'h21);
    check("rstc_next_ld",   32'(ld),    32'h40);
    #1;

    // --- Randomized traffic --------------------------------------------------
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        clr      = 1'b1;
        wr_valid = 1'($urandom_range(0, 1));
        sel      = 3'($urandom);
        bus_in   = 8'($urandom);
        @(posedge clk); #1;
        clr      = 1'b0;
        wr_valid = 1'b0;
      end else if (r == 1) begin
        wr_valid = 1'($urandom_range(0, 1));
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
      end else begin
        do_write(3'($urandom), 8'($urandom));
        if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(0, 2));
      end
    end
    idle_cycles(3);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
